// File: rtl/video_stitch_pkg.sv
// Shared definitions for the video-stitch frame buffer path: AXI encodings,
// pixel packing and the frame-reader state type.
package video_stitch_pkg;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0]  AXI_CACHE_DEF  = 4'b0011;
    localparam int unsigned PIX_PER_BEAT   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } rd_state_t;

endpackage

// File: rtl/axi_frame_burst_reader_if.sv
// AXI4 read channels (AR/R) plus the outgoing beat stream of the frame reader.
// master: the reader (drives AR, RREADY, stream data); slave: memory + sink.
interface axi_frame_burst_reader_if #(
    parameter int unsigned ID_W   = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/axi_frame_burst_reader.sv
// AXI4 read master that fetches one stored frame as back-to-back INCR bursts
// (one outstanding) and streams the beats out with zero-latency pass-through.
// Ports: M_AXI_ACLK/M_AXI_ARESETN clock and sync active-low reset;
//        start/frame_sel launch a frame read; busy/done/err status;
//        bus carries the AR/R channels and the m_axis beat stream.
module axi_frame_burst_reader
    import video_stitch_pkg::*;
#(
    parameter longint unsigned C_M_TARGET_SLAVE_BASE_ADDR = 64'h1000_0000,
    parameter int unsigned     C_M_AXI_BURST_LEN          = 16,
    parameter int unsigned     C_M_AXI_ID_WIDTH           = 1,
    parameter int unsigned     C_M_AXI_ADDR_WIDTH         = 32,
    parameter int unsigned     C_M_AXI_DATA_WIDTH         = 128,
    parameter int unsigned     IMG_HDISP                  = 1280,
    parameter int unsigned     IMG_VDISP                  = 720,
    parameter longint unsigned FRAME_STRIDE               = 64'h0040_0000
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            start,
    input  logic [1:0]                      frame_sel,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    axi_frame_burst_reader_if.master        bus
);

    localparam int unsigned     LEN         = C_M_AXI_BURST_LEN;
    localparam int unsigned     AW          = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned     BEATS       = IMG_HDISP * IMG_VDISP / PIX_PER_BEAT;
    localparam int unsigned     BURSTS      = BEATS / LEN;
    localparam int unsigned     BURST_BYTES = LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam longint unsigned FRAME_BYTES = 64'(BEATS) * 64'(C_M_AXI_DATA_WIDTH / 8);
    localparam int unsigned     BEAT_W      = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned     BURST_W     = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    // Reject frame geometries that do not tile into whole bursts or overlap buffers.
    if ((LEN < 1) || (LEN > 256) || ((LEN & (LEN - 1)) != 0) ||
        ((BEATS % LEN) != 0) || (FRAME_STRIDE < FRAME_BYTES)) begin : g_bad_cfg
        $error("axi_frame_burst_reader: invalid burst length / frame geometry / stride");
    end

    rd_state_t            state_q, state_d;
    logic [1:0]           sel_q;
    logic [BURST_W-1:0]   burst_idx_q;
    logic [BEAT_W-1:0]    beat_idx_q;
    logic                 err_q;

    logic                 beat_hs;
    logic                 last_beat;
    logic                 last_burst;

    assign last_beat  = (beat_idx_q == BEAT_W'(LEN - 1));
    assign last_burst = (burst_idx_q == BURST_W'(BURSTS - 1));
    assign beat_hs    = (state_q == DATA) && bus.rvalid && bus.m_axis_tready;

    // Next state and outputs; the R->stream path is a pure wire so RREADY tracks tready.
    always_comb begin
        state_d            = state_q;
        busy               = 1'b0;
        done               = 1'b0;
        err                = err_q;
        bus.arvalid        = 1'b0;
        bus.rready         = 1'b0;
        bus.m_axis_tvalid  = 1'b0;
        bus.m_axis_tlast   = 1'b0;
        bus.m_axis_tdata   = bus.rdata;
        bus.arid           = '0;
        bus.arlen          = 8'(LEN - 1);
        bus.arsize         = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
        bus.arburst        = AXI_BURST_INCR;
        bus.arlock         = 1'b0;
        bus.arcache        = AXI_CACHE_DEF;
        bus.arprot         = 3'b000;
        bus.arqos          = 4'b0000;
        bus.araddr         = AW'(C_M_TARGET_SLAVE_BASE_ADDR)
                           + AW'(sel_q) * AW'(FRAME_STRIDE)
                           + AW'(burst_idx_q) * AW'(BURST_BYTES);
        case (state_q)
            IDLE: begin
                if (start) state_d = ADDR;
            end
            ADDR: begin
                busy        = 1'b1;
                bus.arvalid = 1'b1;
                if (bus.arready) state_d = DATA;
            end
            DATA: begin
                busy              = 1'b1;
                bus.rready        = bus.m_axis_tready;
                bus.m_axis_tvalid = bus.rvalid;
                bus.m_axis_tlast  = bus.rvalid && last_beat && last_burst;
                if (beat_hs && last_beat) state_d = last_burst ? DONE : ADDR;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, frame select latch, burst/beat counters and sticky error.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            sel_q       <= 2'b00;
            burst_idx_q <= '0;
            beat_idx_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q       <= frame_sel;
                        err_q       <= 1'b0;
                        burst_idx_q <= '0;
                    end
                end
                ADDR: begin
                    if (bus.arready) beat_idx_q <= '0;
                end
                DATA: begin
                    if (beat_hs) begin
                        // Burst end is set by the beat count; RLAST is only checked.
                        if ((bus.rresp != AXI_RESP_OKAY) || (bus.rlast != last_beat)) begin
                            err_q <= 1'b1;
                        end
                        beat_idx_q <= last_beat ? '0 : beat_idx_q + BEAT_W'(1);
                        if (last_beat && !last_burst) begin
                            burst_idx_q <= burst_idx_q + BURST_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
